msg_schedule_gen: RTL and testbench

Parametrised SHA-2 message-schedule generator, the streaming successor to the fixed SHA-256 W-vector builder. It accepts one 16-word message block and emits the schedule words W0..W(ROUNDS-1) one per valid/ready handshake. A rolling 16-word window replaces a full schedule store. It sits between the padding/block-formation stage and the compression-round engine, serving SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).

---
 rtl/msg_schedule_gen.sv | 139 +++++++++++++
 tb/tb_msg_schedule_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule_gen.sv
// rtl/msg_schedule_gen.sv - SHA-2 message schedule generator with a rolling 16-word window
module msg_schedule_gen #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [16*WORD_W-1:0]  message_block,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  w_valid,
  output logic [WORD_W-1:0]     w_data,
  output logic [IDX_W-1:0]      w_index,
  output logic                  w_last,
  output logic                  done
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("msg_schedule_gen: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16) begin : g_bad_rounds
      $error("msg_schedule_gen: ROUNDS must be at least 16");
    end
  endgenerate

  // Rotate/shift amounts for the two small-sigma functions, chosen by word width
  localparam int S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int S0_S = (WORD_W == 64) ? 7  : 3;
  localparam int S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int S1_S = (WORD_W == 64) ? 6  : 10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
  endfunction

  state_t            state_q, state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  logic              hs;
  logic              at_last;
  logic [WORD_W-1:0] new_word;

  assign hs       = w_valid & out_ready;
  assign at_last  = (idx_q == LAST_IDX);
  // window[j] holds W(idx+j), so W(idx+16) needs window 14, 9, 1 and 0
  assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over start and over a final handshake
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (hs && at_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers so the consumer sees glitch-free data
  always_comb begin
    busy    = (state_q == S_RUN);
    w_valid = busy;
    w_last  = busy && at_last;
    w_data  = win_q[0];
    w_index = idx_q;
    done    = done_q;
  end

  // Window, index and done-pulse next values
  always_comb begin
    win_d  = win_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (abort) begin
      idx_d = '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        for (int j = 0; j < 16; j++) begin
          win_d[j] = message_block[16*WORD_W-1-j*WORD_W -: WORD_W];
        end
        idx_d = '0;
      end
    end else if (hs) begin
      if (at_last) begin
        done_d = 1'b1;
      end else begin
        for (int j = 0; j < 15; j++) begin
          win_d[j] = win_q[j+1];
        end
        win_d[15] = new_word;
        idx_d     = idx_q + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 16; j++) win_q[j] <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb/tb_msg_schedule_gen.sv - scoreboard bench for msg_schedule_gen in SHA-256 and SHA-512 shapes
module tb_msg_schedule_gen;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // SHA-256 instance
  logic         a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0;
  logic [511:0] a_msg = '0;
  logic         a_busy, a_valid, a_last, a_done;
  logic [31:0]  a_data;
  logic [5:0]   a_index;

  // SHA-512 instance
  logic          b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
  logic [1023:0] b_msg = '0;
  logic          b_busy, b_valid, b_last, b_done;
  logic [63:0]   b_data;
  logic [6:0]    b_index;

  msg_schedule_gen #(.WORD_W(32), .ROUNDS(64)) u_dut256 (
    .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
    .message_block(a_msg), .out_ready(a_ready), .busy(a_busy), .w_valid(a_valid),
    .w_data(a_data), .w_index(a_index), .w_last(a_last), .done(a_done)
  );

  msg_schedule_gen #(.WORD_W(64), .ROUNDS(80)) u_dut512 (
    .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
    .message_block(b_msg), .out_ready(b_ready), .busy(b_busy), .w_valid(b_valid),
    .w_data(b_data), .w_index(b_index), .w_last(b_last), .done(b_done)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] blk [16];
  logic [63:0] exp_q [$];

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return r32(x, 7) ^ r32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return r32(x, 17) ^ r32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
  endfunction

  // Textbook full-schedule model; pushes every expected word onto the scoreboard
  task automatic push_model(input bit is64, input int rounds);
    logic [63:0] w [80];
    logic [31:0] t32;
    for (int t = 0; t < 16; t++) w[t] = is64 ? blk[t] : {32'h0, blk[t][31:0]};
    for (int t = 16; t < rounds; t++) begin
      if (is64) begin
        w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
      end else begin
        t32  = s1_32(w[t-2][31:0]) + w[t-7][31:0] + s0_32(w[t-15][31:0]) + w[t-16][31:0];
        w[t] = {32'h0, t32};
      end
    end
    for (int t = 0; t < rounds; t++) exp_q.push_back(w[t]);
  endtask

  task automatic set_abc(input bit is64);
    for (int j = 0; j < 16; j++) blk[j] = '0;
    blk[0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
    blk[15] = 64'h18;
  endtask

  // Called at a negedge: presents the block with start for the next edge
  task automatic start_a();
    for (int j = 0; j < 16; j++) a_msg[511-32*j -: 32] = blk[j][31:0];
    exp_q.delete();
    push_model(1'b0, 64);
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
  endtask

  // Consumes the SHA-256 stream; returns at the negedge of the done cycle (or after an abort)
  task automatic stream_a(input bit rnd, input bit chk_abc, input int start_at, input int abort_at);
    bit          stalled;
    logic [31:0] held;
    int          ei;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (a_done) begin
        vectors++;
        if (exp_q.size() != 0) begin
          miscompares++; $display("FAIL a_leftover: got %0d words unsent, want 0", exp_q.size());
        end
        vectors++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
          miscompares++; $display("FAIL a_done_cycle: got valid=%b busy=%b, want 0 0", a_valid, a_busy);
        end
        if (!rnd) begin
          vectors++;
          if (cyc != 64) begin
            miscompares++; $display("FAIL a_done_latency: got %0d, want 64", cyc);
          end
        end
        return;
      end
      vectors++;
      if (a_valid !== 1'b1) begin
        miscompares++; $display("FAIL a_valid: got %b, want 1", a_valid);
      end else if (exp_q.size() == 0) begin
        miscompares++; $display("FAIL a_extra_word: got %h at idx %0d, want none", a_data, a_index);
      end else begin
        ei = 64 - exp_q.size();
        if (a_data !== exp_q[0][31:0] || a_index !== 6'(ei) || a_last !== (ei == 63)) begin
          miscompares++;
          $display("FAIL a_word: got %h idx %0d last %b, want %h idx %0d last %b",
                   a_data, a_index, a_last, exp_q[0][31:0], ei, (ei == 63));
        end
        if (stalled) begin
          vectors++;
          if (a_data !== held) begin
            miscompares++; $display("FAIL a_stall_stable: got %h, want %h", a_data, held);
          end
        end
        if (chk_abc && (ei == 0 || ei == 15 || ei == 16 || ei == 17)) begin
          vectors++;
          if (a_data !== (ei == 0 ? 32'h61626380 : ei == 15 ? 32'h00000018 :
                          ei == 16 ? 32'h61626380 : 32'h000F0000)) begin
            miscompares++; $display("FAIL a_abc_known idx %0d: got %h", ei, a_data);
          end
        end
      end
      a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start = (start_at >= 0 && a_index == 6'(start_at)) ? 1'b1 : 1'b0;
      if (abort_at >= 0 && a_index == 6'(abort_at)) begin
        a_abort = 1'b1;
        a_ready = 1'b1;
        @(negedge clock);
        a_abort = 1'b0;
        vectors++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_index !== 6'd0 || a_done !== 1'b0) begin
          miscompares++;
          $display("FAIL a_abort: got valid=%b busy=%b idx=%0d done=%b, want 0 0 0 0",
                   a_valid, a_busy, a_index, a_done);
        end
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          vectors++;
          if (a_done !== 1'b0 || a_valid !== 1'b0) begin
            miscompares++; $display("FAIL a_abort_quiet: got done=%b valid=%b, want 0 0", a_done, a_valid);
          end
        end
        return;
      end
      stalled = a_valid && !a_ready;
      held    = a_data;
      if (a_valid && a_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clock);
    end
    vectors++; miscompares++;
    $display("FAIL a_timeout: got no done within 1000 cycles, want done");
  endtask

  task automatic check_done_drops_a();
    @(negedge clock);
    vectors++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      miscompares++; $display("FAIL a_done_pulse: got done=%b busy=%b, want 0 0", a_done, a_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if ({a_busy, a_valid, a_last, a_done} !== 4'b0 || a_index !== 6'd0 || a_data !== 32'd0) begin
      miscompares++; $display("FAIL reset_256: got busy=%b valid=%b idx=%0d data=%h, want zeros",
                              a_busy, a_valid, a_index, a_data);
    end
    vectors++;
    if ({b_busy, b_valid, b_last, b_done} !== 4'b0 || b_index !== 7'd0 || b_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_512: got busy=%b valid=%b idx=%0d data=%h, want zeros",
                              b_busy, b_valid, b_index, b_data);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_abc_256();
    set_abc(1'b0);
    start_a();
    stream_a(1'b0, 1'b1, -1, -1);
    check_done_drops_a();
  endtask

  task automatic test_stall();
    set_abc(1'b0);
    start_a();
    stream_a(1'b1, 1'b1, -1, -1);
    check_done_drops_a();
  endtask

  task automatic test_start_abort();
    set_abc(1'b0);
    start_a();
    stream_a(1'b0, 1'b1, 10, 20);
  endtask

  task automatic test_back_to_back();
    set_abc(1'b0);
    start_a();
    stream_a(1'b0, 1'b1, -1, -1);
    for (int j = 0; j < 16; j++) blk[j] = {32'h0, $urandom()};
    start_a();
    vectors++;
    if (a_valid !== 1'b1 || a_data !== blk[0][31:0] || a_index !== 6'd0) begin
      miscompares++; $display("FAIL b2b_first: got valid=%b data=%h idx=%0d, want 1 %h 0",
                              a_valid, a_data, a_index, blk[0][31:0]);
    end
    stream_a(1'b0, 1'b0, -1, -1);
    check_done_drops_a();
  endtask

  task automatic test_async_reset();
    set_abc(1'b0);
    start_a();
    a_ready = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({a_busy, a_valid, a_last, a_done} !== 4'b0 || a_index !== 6'd0 || a_data !== 32'd0) begin
      miscompares++; $display("FAIL async_reset: got busy=%b valid=%b idx=%0d data=%h, want zeros",
                              a_busy, a_valid, a_index, a_data);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    set_abc(1'b0);
    start_a();
    stream_a(1'b0, 1'b1, -1, -1);
    check_done_drops_a();
  endtask

  task automatic test_sha512();
    int  ei;
    bit  fin;
    set_abc(1'b1);
    for (int j = 0; j < 16; j++) b_msg[1023-64*j -: 64] = blk[j];
    exp_q.delete();
    push_model(1'b1, 80);
    b_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (b_done) begin
        vectors++;
        if (cyc != 80 || exp_q.size() != 0) begin
          miscompares++; $display("FAIL b_done: got cycle %0d left %0d, want 80 0", cyc, exp_q.size());
        end
        fin = 1'b1;
      end else begin
        vectors++;
        if (b_valid !== 1'b1 || exp_q.size() == 0) begin
          miscompares++; $display("FAIL b_valid: got %b, want 1", b_valid);
        end else begin
          ei = 80 - exp_q.size();
          if (b_data !== exp_q[0] || b_index !== 7'(ei) || b_last !== (ei == 79)) begin
            miscompares++;
            $display("FAIL b_word: got %h idx %0d last %b, want %h idx %0d last %b",
                     b_data, b_index, b_last, exp_q[0], ei, (ei == 79));
          end
          if (ei == 16) begin
            vectors++;
            if (b_data !== 64'h6162638000000000) begin
              miscompares++; $display("FAIL b_w16: got %h, want 6162638000000000", b_data);
            end
          end
          void'(exp_q.pop_front());
        end
        @(negedge clock);
      end
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL b_timeout: got no done, want done");
    end
  endtask

  initial begin
    test_reset();
    test_abc_256();
    test_stall();
    test_start_abort();
    test_back_to_back();
    test_async_reset();
    test_sha512();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
